mmio_responder: RTL and testbench
=================================

# mmio_responder

Memory-mapped I/O responder on the CPU memory bus. It answers the same `mem_cmd`/`mem_addr`/`write_data` transactions that the RAM answers, but for the I/O region (`mem_addr[8] = 1`). It holds the LED output register, synchronises the switches and keys, latches key presses until software reads them, and provides an optional tick timer. `read_data` and `read_en` feed the top-level tri-state read bus next to the RAM's driver.

## Interface
Parameters:
- `LED_ADDR`, 9'h100: write-only LED register.
- `SW_ADDR`, 9'h140: read-only switch register.
- `KEY_ADDR`, 9'h141: key-press capture register; reading it clears it.
- `TIMER_ADDR`, 9'h142: tick counter; a read returns the count, any write clears it.
- `TIMER_DIV`, 50000: clock cycles per tick (must be ≥ 2).

Ports:
- `clk` in 1: single clock; one clock, reset is asynchronous and active-low.
- `reset` in 1: one clock; reset is asynchronous and active-low (0 = reset).
- `mem_cmd` in 2: bus command; 2'b00 = MNONE, 2'b01 = MREAD, 2'b10 = MWRITE, 2'b11 = ignored.
- `mem_addr` in 9: bus address.
- `write_data` in 16: CPU store data.
- `read_data` out 16: responder read data.
- `read_en` out 1: high when this block owns the read bus; it enables the top-level tri-state driver.
- `SW` in 10: raw switches, asynchronous.
- `KEY` in 4: raw keys, asynchronous, active-low (pressed = 0).
- `LEDR` out 8: LED register.

## Operation
- Address decode is exact-match on all 9 bits. Unmapped addresses produce no state change and `read_en = 0`.
- MWRITE to `LED_ADDR`: `LEDR <= write_data[7:0]`. Upper bits are ignored.
- MWRITE to `SW_ADDR` or `KEY_ADDR`: no effect.
- Switch path: `SW` passes through two flops. MREAD at `SW_ADDR` returns `{6'b0, sw_sync[9:0]}`.
- Key path:
  - `KEY` passes through two flops, followed by a third "previous" flop.
  - A press is detected when prev = 1 and sync = 0. It sets the sticky bit `cap[i]`.
  - MREAD at `KEY_ADDR` returns `{12'b0, cap}`. On that clock edge, `cap <= new_press`.
  - A press detected in the same cycle as the clearing read stays set (set wins).
- `read_en = (mem_cmd == MREAD) & (address hits a readable register)`. It is combinational.
- `read_data` is combinational from registered sources and is 16'h0000 whenever `read_en = 0`.
- No bus wait states. The CPU samples read data in the same cycle it asserts MREAD.

## Timing
- Reset (asynchronous assert, synchronous deassert at the top level) sets:
  - `LEDR = 0`, `cap = 0`.
  - Switch synchroniser flops = 0.
  - Key synchroniser flops and prev flop = 1'b1, so no false press is detected on release from reset.
  - Timer prescaler and counter = 0.
- Reset mid-transaction drops any pending write. After reset, `read_en` follows `mem_cmd` combinationally.
- LED write: `LEDR` updates on the rising edge at the end of the MWRITE cycle, so it is visible in the next cycle.
- Switch latency: a change on `SW` is readable 2 clocks later.
- Key latency: a press is visible in `cap` 3 edges after `KEY` falls.
  - A held key sets `cap` once.
  - Releasing and pressing again is required to set it again.
  - A 1-cycle glitch after sync still sets it. There is no debounce.
- Back-to-back KEY reads: the second read returns only presses detected after the first read's edge.

## Configuration
- `MMIO_TIMER_EN` defined:
  - A prescaler counts 0..`TIMER_DIV`-1. On the wrap, the 16-bit `tick` increments, and `tick` wraps from 16'hFFFF to 0.
  - MREAD at `TIMER_ADDR` returns `tick`.
  - MWRITE at `TIMER_ADDR` clears both the prescaler and `tick` on that edge. The clear wins over a coincident increment.
- `MMIO_TIMER_EN` undefined:
  - No timer logic is built.
  - `TIMER_ADDR` is treated as unmapped: reads give `read_en = 0`, and writes are ignored.

## Test plan
- Reset, with `KEY` = 4'hF held low then released: `LEDR` = 0, `read_en` = 0, and a KEY read returns 16'h0000.
- MWRITE 16'hABCD to 9'h100: `LEDR` = 8'hCD next cycle. MWRITE to 9'h0FF: `LEDR` unchanged, `read_en` = 0.
- `SW` = 10'h2A5, wait 2 clocks, MREAD 9'h140: `read_en` = 1, `read_data` = 16'h02A5. The same read with `mem_cmd` = MNONE gives `read_en` = 0 and `read_data` = 0.
- Pulse `KEY[2]` low for 5 cycles, then read 9'h141 twice: 16'h0004 then 16'h0000. Repeat with a `KEY[0]` press landing on the read edge: the second read returns 16'h0001.
- With `MMIO_TIMER_EN` and `TIMER_DIV` = 4: after 40 cycles a read of 9'h142 returns 16'h000A. Write 9'h142, then read immediately: 16'h0000. Preload to 16'hFFFF via force: it wraps to 0 after 4 cycles.
- Without `MMIO_TIMER_EN`: MREAD 9'h142 gives `read_en` = 0.

Source files
------------

// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_responder
// Brief    : I/O-region bus responder: LED register, synchronised switches,
//            sticky key-press capture and an optional tick timer
//            (built when MMIO_TIMER_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module mmio_responder #(
    parameter logic [8:0] LED_ADDR   = 9'h100,
    parameter logic [8:0] SW_ADDR    = 9'h140,
    parameter logic [8:0] KEY_ADDR   = 9'h141,
    parameter logic [8:0] TIMER_ADDR = 9'h142,
    parameter int         TIMER_DIV  = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        read_en,
    input  logic [9:0]  SW,
    input  logic [3:0]  KEY,
    output logic [7:0]  LEDR
);

    localparam logic [1:0] c_MREAD  = 2'b01;
    localparam logic [1:0] c_MWRITE = 2'b10;

    logic        w_rd;
    logic        w_wr;
    logic        w_hit_led;
    logic        w_hit_sw;
    logic        w_hit_key;
    logic        w_hit_timer;
    logic        w_key_clr;
    logic [3:0]  w_new_press;
    logic [15:0] w_tick_val;

    logic [7:0]  r_ledr;
    logic [9:0]  r_sw_meta;
    logic [9:0]  r_sw_sync;
    logic [3:0]  r_key_meta;
    logic [3:0]  r_key_sync;
    logic [3:0]  r_key_prev;
    logic [3:0]  r_cap;

    assign w_rd      = (mem_cmd == c_MREAD);
    assign w_wr      = (mem_cmd == c_MWRITE);
    assign w_hit_led = (mem_addr == LED_ADDR);
    assign w_hit_sw  = (mem_addr == SW_ADDR);
    assign w_hit_key = (mem_addr == KEY_ADDR);

    // A falling edge on the synchronised key (active-low) is a press.
    assign w_new_press = r_key_prev & ~r_key_sync;
    assign w_key_clr   = w_rd & w_hit_key;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ledr     <= 8'h00;
            r_sw_meta  <= 10'h000;
            r_sw_sync  <= 10'h000;
            r_key_meta <= 4'hF;
            r_key_sync <= 4'hF;
            r_key_prev <= 4'hF;
            r_cap      <= 4'h0;
        end else begin
            r_sw_meta  <= SW;
            r_sw_sync  <= r_sw_meta;
            r_key_meta <= KEY;
            r_key_sync <= r_key_meta;
            r_key_prev <= r_key_sync;
            if (w_wr && w_hit_led) begin
                r_ledr <= write_data[7:0];
            end
            // A press arriving on the clearing read survives it.
            if (w_key_clr) begin
                r_cap <= w_new_press;
            end else begin
                r_cap <= r_cap | w_new_press;
            end
        end
    end

`ifdef MMIO_TIMER_EN
    localparam int                c_PS_W   = $clog2(TIMER_DIV);
    localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(TIMER_DIV - 1);

    logic [c_PS_W-1:0] r_prescale;
    logic [15:0]       r_tick;

    assign w_hit_timer = (mem_addr == TIMER_ADDR);
    assign w_tick_val  = r_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prescale <= '0;
            r_tick     <= 16'h0000;
        end else if (w_wr && w_hit_timer) begin
            r_prescale <= '0;
            r_tick     <= 16'h0000;
        end else if (r_prescale == c_PS_MAX) begin
            r_prescale <= '0;
            r_tick     <= r_tick + 16'h0001;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end
`else
    localparam int c_unused_div       = TIMER_DIV;
    localparam logic [8:0] c_unused_t = TIMER_ADDR;

    assign w_hit_timer = 1'b0;
    assign w_tick_val  = 16'h0000;
`endif

    assign read_en = w_rd & (w_hit_sw | w_hit_key | w_hit_timer);

    always_comb begin
        read_data = 16'h0000;
        if (read_en) begin
            if (w_hit_sw) begin
                read_data = {6'b0, r_sw_sync};
            end else if (w_hit_key) begin
                read_data = {12'b0, r_cap};
            end else begin
                read_data = w_tick_val;
            end
        end
    end

    assign LEDR = r_ledr;

    logic w_unused;
    assign w_unused = &{1'b0, write_data[15:8]};

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_responder
// Brief    : Directed self-checking bench for mmio_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_responder;

    localparam logic [1:0] c_MNONE  = 2'b00;
    localparam logic [1:0] c_MREAD  = 2'b01;
    localparam logic [1:0] c_MWRITE = 2'b10;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        read_en;
    logic [9:0]  SW;
    logic [3:0]  KEY;
    logic [7:0]  LEDR;

    int tests;
    int fails;

    mmio_responder #(
        .LED_ADDR   (9'h100),
        .SW_ADDR    (9'h140),
        .KEY_ADDR   (9'h141),
        .TIMER_ADDR (9'h142),
        .TIMER_DIV  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .read_en    (read_en),
        .SW         (SW),
        .KEY        (KEY),
        .LEDR       (LEDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = data;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        KEY   = 4'h0;
        SW    = 10'h000;
        bus(c_MNONE, 9'h000, 16'h0000);
        repeat (3) step();
        KEY = 4'hF;
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
        tests++;
        if (LEDR !== 8'h00) begin
            fails++;
            $display("FAIL reset_ledr: got %h expected 00", LEDR);
        end
        #1;
        tests++;
        if (read_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_read_en: got %b expected 0", read_en);
        end
        bus(c_MREAD, 9'h141, 16'h0000);
        #1;
        tests++;
        if (read_en !== 1'b1 || read_data !== 16'h0000) begin
            fails++;
            $display("FAIL reset_key_read: read_en %b data %h expected 1 0000", read_en, read_data);
        end
        step();
        bus(c_MNONE, 9'h000, 16'h0000);
    endtask

    task automatic test_led();
        bus(c_MWRITE, 9'h100, 16'hABCD);
        #1;
        tests++;
        if (read_en !== 1'b0) begin
            fails++;
            $display("FAIL led_write_read_en: got %b expected 0", read_en);
        end
        step();
        bus(c_MNONE, 9'h000, 16'h0000);
        tests++;
        if (LEDR !== 8'hCD) begin
            fails++;
            $display("FAIL led_write: got %h expected cd", LEDR);
        end
        bus(c_MWRITE, 9'h0FF, 16'h1234);
        #1;
        tests++;
        if (read_en !== 1'b0) begin
            fails++;
            $display("FAIL unmapped_read_en: got %b expected 0", read_en);
        end
        step();
        bus(c_MWRITE, 9'h140, 16'h00FF);
        step();
        bus(2'b11, 9'h100, 16'h0055);
        step();
        bus(c_MNONE, 9'h000, 16'h0000);
        tests++;
        if (LEDR !== 8'hCD) begin
            fails++;
            $display("FAIL led_unchanged: got %h expected cd", LEDR);
        end
        bus(c_MREAD, 9'h100, 16'h0000);
        #1;
        tests++;
        if (read_en !== 1'b0 || read_data !== 16'h0000) begin
            fails++;
            $display("FAIL led_not_readable: read_en %b data %h expected 0 0000", read_en, read_data);
        end
        step();
        bus(c_MNONE, 9'h000, 16'h0000);
    endtask

    task automatic test_switch();
        SW = 10'h2A5;
        step();
        bus(c_MREAD, 9'h140, 16'h0000);
        #1;
        tests++;
        if (read_data !== 16'h0000) begin
            fails++;
            $display("FAIL sw_latency_early: got %h expected 0000", read_data);
        end
        step();
        tests++;
        if (read_en !== 1'b1 || read_data !== 16'h02A5) begin
            fails++;
            $display("FAIL sw_read: read_en %b data %h expected 1 02a5", read_en, read_data);
        end
        bus(c_MNONE, 9'h140, 16'h0000);
        #1;
        tests++;
        if (read_en !== 1'b0 || read_data !== 16'h0000) begin
            fails++;
            $display("FAIL sw_mnone: read_en %b data %h expected 0 0000", read_en, read_data);
        end
        bus(2'b11, 9'h140, 16'h0000);
        #1;
        tests++;
        if (read_en !== 1'b0) begin
            fails++;
            $display("FAIL sw_cmd11: read_en %b expected 0", read_en);
        end
        bus(c_MNONE, 9'h000, 16'h0000);
        step();
    endtask

    task automatic test_key_capture();
        KEY = 4'hB;
        repeat (5) step();
        KEY = 4'hF;
        repeat (3) step();
        bus(c_MREAD, 9'h141, 16'h0000);
        #1;
        tests++;
        if (read_data !== 16'h0004) begin
            fails++;
            $display("FAIL key2_first_read: got %h expected 0004", read_data);
        end
        step();
        tests++;
        if (read_data !== 16'h0000) begin
            fails++;
            $display("FAIL key2_second_read: got %h expected 0000", read_data);
        end
        bus(c_MNONE, 9'h000, 16'h0000);
        step();
        KEY = 4'h5;
        repeat (4) step();
        KEY = 4'hF;
        bus(c_MREAD, 9'h141, 16'h0000);
        #1;
        tests++;
        if (read_data !== 16'h000A) begin
            fails++;
            $display("FAIL key13_read: got %h expected 000a", read_data);
        end
        step();
        bus(c_MNONE, 9'h000, 16'h0000);
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        KEY = 4'hE;
        repeat (2) step();
        // press is detected during this read cycle and lands on its edge
        bus(c_MREAD, 9'h141, 16'h0000);
        #1;
        tests++;
        if (read_data !== 16'h0000) begin
            fails++;
            $display("FAIL b2b_first_read: got %h expected 0000", read_data);
        end
        step();
        tests++;
        if (read_data !== 16'h0001) begin
            fails++;
            $display("FAIL b2b_set_wins: got %h expected 0001", read_data);
        end
        step();
        tests++;
        if (read_data !== 16'h0000) begin
            fails++;
            $display("FAIL b2b_cleared: got %h expected 0000", read_data);
        end
        bus(c_MNONE, 9'h000, 16'h0000);
        repeat (4) step();
        bus(c_MREAD, 9'h141, 16'h0000);
        #1;
        tests++;
        if (read_data !== 16'h0000) begin
            fails++;
            $display("FAIL held_key_once: got %h expected 0000", read_data);
        end
        step();
        bus(c_MNONE, 9'h000, 16'h0000);
        KEY = 4'hF;
        repeat (3) step();
        KEY = 4'hE;
        repeat (4) step();
        bus(c_MREAD, 9'h141, 16'h0000);
        #1;
        tests++;
        if (read_data !== 16'h0001) begin
            fails++;
            $display("FAIL repress: got %h expected 0001", read_data);
        end
        step();
        bus(c_MNONE, 9'h000, 16'h0000);
        KEY = 4'hF;
        repeat (3) step();
    endtask

`ifdef MMIO_TIMER_EN
    task automatic test_timer();
        bus(c_MWRITE, 9'h142, 16'h0000);
        step();
        bus(c_MNONE, 9'h000, 16'h0000);
        repeat (40) step();
        bus(c_MREAD, 9'h142, 16'h0000);
        #1;
        tests++;
        if (read_en !== 1'b1 || read_data !== 16'h000A) begin
            fails++;
            $display("FAIL timer_count: read_en %b data %h expected 1 000a", read_en, read_data);
        end
        bus(c_MWRITE, 9'h142, 16'h0000);
        step();
        bus(c_MREAD, 9'h142, 16'h0000);
        #1;
        tests++;
        if (read_data !== 16'h0000) begin
            fails++;
            $display("FAIL timer_clear: got %h expected 0000", read_data);
        end
        force dut.r_tick = 16'hFFFF;
        #1;
        release dut.r_tick;
        repeat (3) step();
        tests++;
        if (read_data !== 16'hFFFF) begin
            fails++;
            $display("FAIL timer_preload: got %h expected ffff", read_data);
        end
        step();
        tests++;
        if (read_data !== 16'h0000) begin
            fails++;
            $display("FAIL timer_wrap: got %h expected 0000", read_data);
        end
        bus(c_MNONE, 9'h000, 16'h0000);
        step();
    endtask
`else
    task automatic test_timer();
        bus(c_MREAD, 9'h142, 16'h0000);
        #1;
        tests++;
        if (read_en !== 1'b0 || read_data !== 16'h0000) begin
            fails++;
            $display("FAIL timer_absent: read_en %b data %h expected 0 0000", read_en, read_data);
        end
        bus(c_MWRITE, 9'h142, 16'h0077);
        step();
        bus(c_MNONE, 9'h000, 16'h0000);
        tests++;
        if (LEDR !== 8'hCD) begin
            fails++;
            $display("FAIL timer_absent_write: ledr %h expected cd", LEDR);
        end
        step();
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_led();
        test_switch();
        test_key_capture();
        test_back_to_back();
        test_timer();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
